msu_data_fetch: RTL and testbench
=================================

Name: msu_data_fetch

Overview:
- Downstream servicing stage for the MSU-1 data-track port.
- Consumes the seek/read strobes from the MSU register block: data_addr, data_seek, data_req.
- Fetches 32-bit words from the data-file memory interface into a byte prefetch FIFO.
- Returns the current byte on data and a one-cycle data_ack pulse once a seek has been satisfied.

Parameters:
- DEPTH, 16: byte FIFO depth; power of two, minimum 8.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- data_addr  in  32  byte address from MSU register block; sampled on data_seek rising edge
- data_seek  in  1  level, high from seek write until ack
- data_req  in  1  one-cycle pulse: current byte consumed, advance
- data  out  8  current data byte (registered)
- data_ack  out  1  one-cycle pulse, seek complete
- mem_addr  out  32  word-aligned byte address, bits [1:0] always 0
- mem_rd  out  1  one-cycle read request pulse
- mem_rdata  in  32  read word, little-endian: byte0 = [7:0]
- mem_valid  in  1  one-cycle pulse, mem_rdata valid; exactly one per mem_rd, any latency ≥1
- underflow  out  1  sticky: data_req seen with FIFO empty; cleared by next seek

Behaviour:
- Reset: RST is asynchronous and active-high. While it is asserted:
  - data=0, data_ack=0, mem_rd=0, mem_addr=0, underflow=0.
  - FIFO count=0, state=IDLE, skip=0.
- Seek detection: a rising edge of data_seek (registered previous value) starts a seek.
  - Flush FIFO (count=0).
  - mem_addr <= {data_addr[31:2],2'b00}; skip <= data_addr[1:0].
  - underflow <= 0; pending_ack <= 1.
  - If a read is outstanding, go to DISCARD, otherwise to IDLE.
- FSM states:
  - IDLE: if (DEPTH − count) ≥ 4 → assert mem_rd for one cycle, go to WAIT.
  - WAIT: on mem_valid:
    - Push bytes skip..3 of mem_rdata into the FIFO in ascending order.
    - skip <= 0; mem_addr <= mem_addr+4; go to IDLE.
    - A new seek edge in the same cycle as mem_valid: drop the response and apply the seek (go to IDLE).
    - A new seek edge without mem_valid: go to DISCARD.
  - DISCARD: wait for mem_valid, drop the response, go to IDLE. A further seek edge here re-latches address/skip and stays in DISCARD.
- mem_rd is never asserted while a read is outstanding.
- FIFO:
  - Circular byte buffer with a 4-byte-wide push.
  - Count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Overflow is impossible by the free-space ≥4 check.
- data register:
  - Loaded with the head byte the cycle after it becomes head: after a pop, or after a push into an empty FIFO.
  - Otherwise it holds its value.
- data_req:
  - FIFO non-empty: pop; data shows the new head next cycle if one exists, else holds.
  - FIFO empty: set underflow; the next byte pushed still appears as the current byte, with no extra pop.
  - Simultaneous push and pop in one cycle: both are applied; count += pushed − 1.
- data_ack:
  - Pulses exactly one cycle, in the cycle data first holds the first byte after a seek. That is one cycle after the first push, so ack latency is mem latency + 2.
  - pending_ack then clears.
  - A seek superseded before completion produces no ack for the old seek.
- mem_addr increments modulo 2^32 (wrap from 0xFFFFFFFC to 0).

Test Plan:
- Aligned seek: data_addr=0x100, mem latency 3, words 0x44332211, 0x88776655 …
  - Expect data=0x11 with a single data_ack pulse, mem_addr=0x100 on the first mem_rd.
  - Then 3 data_req pulses give 0x22, 0x33, 0x44.
- Unaligned seek: data_addr=0x203, word at 0x200 = 0xDDCCBBAA, word at 0x204 = 0x04030201.
  - Expect data=0xDD at ack; next req gives 0x01.
- Prefetch limit: DEPTH=16, no data_req, mem latency 1.
  - Expect exactly 4 mem_rd pulses after the seek, then mem_rd stays low.
  - One data_req still leaves free space 1 < 4, so no new read issues.
- Seek during outstanding read: seek 0x000, then seek 0x400 before mem_valid.
  - Stale word discarded; next mem_rd addr=0x400; exactly one data_ack, with the byte from 0x400.
- Underflow: mem latency 20, data_req pulsed right after ack with FIFO empty.
  - Expect underflow=1; next byte appears on data.
  - A subsequent seek clears underflow.
- Async reset mid-WAIT: assert RST without a clock edge.
  - All outputs are reset immediately.
  - A late mem_valid after release is ignored: IDLE state, no FIFO push.

Source files
------------

// File: rtl/msu_data_fetch_if.sv
// Data-track and data-file memory signals of msu_data_fetch.
// master: the fetch unit; slave: the MSU register block plus the memory behind it.
interface msu_data_fetch_if;
  logic [31:0] data_addr;
  logic        data_seek;
  logic        data_req;
  logic [7:0]  data;
  logic        data_ack;
  logic        underflow;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    input  data_addr, data_seek, data_req, mem_rdata, mem_valid,
    output data, data_ack, underflow, mem_addr, mem_rd
  );

  modport slave (
    output data_addr, data_seek, data_req, mem_rdata, mem_valid,
    input  data, data_ack, underflow, mem_addr, mem_rd
  );
endinterface

// File: rtl/msu_data_fetch.sv
// MSU-1 data-track fetch: on a seek, streams 32-bit memory words into a byte
// prefetch FIFO and presents the current byte with a one-shot seek acknowledge.
module msu_data_fetch #(
  parameter int unsigned DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  msu_data_fetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state;
  logic          seek_d;
  logic [1:0]    skip;
  logic [31:0]   addr_q;
  logic          rd_q;
  logic [7:0]    data_q;
  logic          ack_q;
  logic          pending_ack;
  logic          underflow_q;
  logic          head_new;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    fifo [DEPTH];

  logic          seek_edge;
  logic          push;
  logic          pop;
  logic [2:0]    push_n;
  logic [CW-1:0] count_next;

  always_comb begin
    seek_edge  = bus.data_seek & ~seek_d;
    push       = (state == WAIT) && bus.mem_valid && !seek_edge;
    push_n     = push ? (3'd4 - {1'b0, skip}) : '0;
    pop        = bus.data_req && (count != '0) && !seek_edge;
    count_next = count + CW'(push_n) - CW'(pop);
  end

  // Bytes skip..3 of the word land in consecutive FIFO slots starting at wr_ptr.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i >= 32'(skip)) begin
          fifo[wr_ptr + PW'(i - 32'(skip))] <= bus.mem_rdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      seek_d      <= 1'b0;
      skip        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      pending_ack <= 1'b0;
      underflow_q <= 1'b0;
      head_new    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      seek_d <= bus.data_seek;
      rd_q   <= 1'b0;
      ack_q  <= 1'b0;
      if (seek_edge) begin
        // A seek overrides any push, pop or head reload in the same cycle.
        count       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        head_new    <= 1'b0;
        addr_q      <= {bus.data_addr[31:2], 2'b00};
        skip        <= bus.data_addr[1:0];
        underflow_q <= 1'b0;
        pending_ack <= 1'b1;
        state       <= ((state != IDLE) && !bus.mem_valid) ? DISCARD : IDLE;
      end else begin
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + PW'(push_n);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (bus.data_req && (count == '0)) underflow_q <= 1'b1;
        head_new <= (pop && (count_next != '0)) || (push && (count == '0));
        if (head_new) begin
          data_q <= fifo[rd_ptr];
          if (pending_ack) begin
            ack_q       <= 1'b1;
            pending_ack <= 1'b0;
          end
        end
        case (state)
          IDLE: begin
            if ((CW'(DEPTH) - count) >= CW'(4)) begin
              rd_q  <= 1'b1;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (bus.mem_valid) begin
              skip   <= '0;
              addr_q <= addr_q + 32'd4;
              state  <= IDLE;
            end
          end
          DISCARD: begin
            if (bus.mem_valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.data_ack  = ack_q;
  assign bus.underflow = underflow_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = rd_q;
endmodule

// File: tb/tb_msu_data_fetch.sv
// Bench for msu_data_fetch: a seek to address A must yield the byte stream
// A, A+1, A+2, ... of a word-addressed little-endian memory.
module tb_msu_data_fetch;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  msu_data_fetch_if bus ();
  msu_data_fetch #(.DEPTH(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Memory contents: explicit words where a test needs them, a fixed hash elsewhere.
  logic [31:0] mem_init [logic [31:0]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pend_q[$];
  logic [31:0] rd_log[$];
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;
  int unsigned rd_cnt = 0;
  int unsigned ack_cnt = 0;

  // Memory responder and pulse counters; the memory is not reset with the DUT.
  initial begin
    req_t r;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      bus.mem_valid = 1'b0;
      if (bus.mem_rd === 1'b1) begin
        r.addr = bus.mem_addr;
        r.due  = cyc + mem_lat - 1;
        pend_q.push_back(r);
        rd_log.push_back(bus.mem_addr);
        rd_cnt++;
      end
      if (bus.data_ack === 1'b1) ack_cnt++;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = word_at(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic seek_to(input logic [31:0] a);
    bus.data_seek = 1'b0;
    step();
    bus.data_addr = a;
    bus.data_seek = 1'b1;
  endtask

  task automatic wait_ack(input int unsigned budget, output int unsigned k, output bit got);
    got = 1'b0;
    k = 0;
    while (!got && k < budget) begin
      step();
      k++;
      if (bus.data_ack === 1'b1) got = 1'b1;
    end
    bus.data_seek = 1'b0;
  endtask

  task automatic pulse_req();
    bus.data_req = 1'b1;
    step();
    bus.data_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step(2);
    tests_run++; if (bus.data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h expected 0", bus.data); end
    tests_run++; if (bus.data_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %0b expected 0", bus.data_ack); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd: got %0b expected 0", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow: got %0b expected 0", bus.underflow); end
    RST = 1'b0;
  endtask

  task automatic test_aligned();
    int unsigned k, a0, r0;
    bit got;
    logic [31:0] first;
    mem_init[32'h100] = 32'h4433_2211;
    mem_init[32'h104] = 32'h8877_6655;
    mem_lat = 3;
    step(60);
    a0 = ack_cnt;
    r0 = rd_cnt;
    seek_to(32'h100);
    wait_ack(40, k, got);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL aligned_ack: no data_ack within 40 cycles"); end
    tests_run++; if (k !== mem_lat + 3) begin tests_failed++; $display("FAIL aligned_latency: got %0d expected %0d", k, mem_lat + 3); end
    tests_run++; if (bus.data !== 8'h11) begin tests_failed++; $display("FAIL aligned_first: got %0h expected 11", bus.data); end
    first = (rd_log.size() > r0) ? rd_log[r0] : 32'hDEAD_BEEF;
    tests_run++; if (first !== 32'h100) begin tests_failed++; $display("FAIL aligned_mem_addr: got %0h expected 100", first); end
    step();
    tests_run++; if (bus.data_ack !== 1'b0) begin tests_failed++; $display("FAIL aligned_ack_width: got %0b expected 0", bus.data_ack); end
    for (int i = 1; i <= 3; i++) begin
      pulse_req();
      tests_run++; if (bus.data !== byte_at(32'h100 + 32'(i))) begin tests_failed++; $display("FAIL aligned_byte%0d: got %0h expected %0h", i, bus.data, byte_at(32'h100 + 32'(i))); end
    end
    tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL aligned_ack_count: got %0d expected 1", ack_cnt - a0); end
  endtask

  task automatic test_unaligned();
    int unsigned k;
    bit got;
    mem_init[32'h200] = 32'hDDCC_BBAA;
    mem_init[32'h204] = 32'h0403_0201;
    mem_lat = 1;
    step(30);
    seek_to(32'h203);
    wait_ack(40, k, got);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL unaligned_ack: no data_ack within 40 cycles"); end
    tests_run++; if (bus.data !== 8'hDD) begin tests_failed++; $display("FAIL unaligned_first: got %0h expected dd", bus.data); end
    pulse_req();
    tests_run++; if (bus.data !== 8'h01) begin tests_failed++; $display("FAIL unaligned_next: got %0h expected 01", bus.data); end
    pulse_req();
    tests_run++; if (bus.data !== 8'h02) begin tests_failed++; $display("FAIL unaligned_next2: got %0h expected 02", bus.data); end
  endtask

  task automatic test_prefetch_limit();
    int unsigned k, r0;
    bit got;
    mem_lat = 1;
    step(30);
    r0 = rd_cnt;
    seek_to(32'h600);
    wait_ack(40, k, got);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL prefetch_ack: no data_ack within 40 cycles"); end
    step(40);
    tests_run++; if (rd_cnt - r0 !== 4) begin tests_failed++; $display("FAIL prefetch_reads: got %0d expected 4", rd_cnt - r0); end
    pulse_req();
    step(20);
    tests_run++; if (rd_cnt - r0 !== 4) begin tests_failed++; $display("FAIL prefetch_reads_after_pop: got %0d expected 4", rd_cnt - r0); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL prefetch_mem_rd_low: got %0b expected 0", bus.mem_rd); end
    tests_run++; if (bus.data !== byte_at(32'h601)) begin tests_failed++; $display("FAIL prefetch_data: got %0h expected %0h", bus.data, byte_at(32'h601)); end
  endtask

  task automatic test_seek_outstanding();
    int unsigned k, a0, r0, n;
    bit got;
    logic [31:0] rd0, rd1;
    mem_init[32'h000] = 32'hA0B0_C0D0;
    mem_init[32'h400] = 32'h1357_9BDF;
    mem_lat = 8;
    step(30);
    a0 = ack_cnt;
    r0 = rd_cnt;
    seek_to(32'h000);
    n = 0;
    while (rd_cnt == r0 && n < 10) begin step(); n++; end
    tests_run++; if (rd_cnt == r0) begin tests_failed++; $display("FAIL outstanding_first_rd: no mem_rd within 10 cycles"); end
    step(2);
    seek_to(32'h400);
    wait_ack(60, k, got);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL outstanding_ack: no data_ack within 60 cycles"); end
    tests_run++; if (bus.data !== 8'hDF) begin tests_failed++; $display("FAIL outstanding_data: got %0h expected df", bus.data); end
    rd0 = (rd_log.size() > r0) ? rd_log[r0] : 32'hDEAD_BEEF;
    rd1 = (rd_log.size() > r0 + 1) ? rd_log[r0 + 1] : 32'hDEAD_BEEF;
    tests_run++; if (rd0 !== 32'h000) begin tests_failed++; $display("FAIL outstanding_rd0: got %0h expected 0", rd0); end
    tests_run++; if (rd1 !== 32'h400) begin tests_failed++; $display("FAIL outstanding_rd1: got %0h expected 400", rd1); end
    step(3);
    tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL outstanding_ack_count: got %0d expected 1", ack_cnt - a0); end
  endtask

  task automatic test_underflow();
    int unsigned k, n;
    bit got;
    mem_init[32'h500] = 32'h5544_3322;
    mem_init[32'h504] = 32'h9988_7766;
    mem_lat = 20;
    step(60);
    seek_to(32'h503);
    wait_ack(80, k, got);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL underflow_ack: no data_ack within 80 cycles"); end
    tests_run++; if (bus.data !== 8'h55) begin tests_failed++; $display("FAIL underflow_first: got %0h expected 55", bus.data); end
    pulse_req();
    tests_run++; if (bus.data !== 8'h55) begin tests_failed++; $display("FAIL underflow_hold: got %0h expected 55", bus.data); end
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_early: got %0b expected 0", bus.underflow); end
    pulse_req();
    tests_run++; if (bus.underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_set: got %0b expected 1", bus.underflow); end
    n = 0;
    while (bus.data !== 8'h66 && n < 40) begin step(); n++; end
    tests_run++; if (bus.data !== 8'h66) begin tests_failed++; $display("FAIL underflow_next_byte: got %0h expected 66", bus.data); end
    tests_run++; if (bus.underflow !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky: got %0b expected 1", bus.underflow); end
    pulse_req();
    tests_run++; if (bus.data !== 8'h77) begin tests_failed++; $display("FAIL underflow_after: got %0h expected 77", bus.data); end
    seek_to(32'h540);
    step();
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear: got %0b expected 0", bus.underflow); end
    wait_ack(80, k, got);
    tests_run++; if (bus.data !== byte_at(32'h540)) begin tests_failed++; $display("FAIL underflow_reseek: got %0h expected %0h", bus.data, byte_at(32'h540)); end
  endtask

  task automatic test_random();
    int unsigned k, a0, npops, gap;
    bit got;
    logic [31:0] a;
    for (int it = 0; it < 12; it++) begin
      mem_lat = $urandom_range(1, 5);
      a = (it == 0) ? 32'hFFFF_FFFA : $urandom();
      a0 = ack_cnt;
      seek_to(a);
      wait_ack(100, k, got);
      tests_run++; if (!got) begin tests_failed++; $display("FAIL rand%0d_ack: no data_ack within 100 cycles", it); end
      tests_run++; if (bus.data !== byte_at(a)) begin tests_failed++; $display("FAIL rand%0d_first: addr %0h got %0h expected %0h", it, a, bus.data, byte_at(a)); end
      npops = $urandom_range(4, 12);
      for (int j = 1; j <= int'(npops); j++) begin
        gap = $urandom_range(2 * mem_lat + 6, 2 * mem_lat + 12);
        step(gap);
        pulse_req();
        tests_run++; if (bus.data !== byte_at(a + 32'(j))) begin tests_failed++; $display("FAIL rand%0d_byte%0d: addr %0h got %0h expected %0h", it, j, a + 32'(j), bus.data, byte_at(a + 32'(j))); end
      end
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_underflow: got %0b expected 0", it, bus.underflow); end
      tests_run++; if (ack_cnt - a0 !== 1) begin tests_failed++; $display("FAIL rand%0d_ack_count: got %0d expected 1", it, ack_cnt - a0); end
    end
  endtask

  task automatic test_async_reset();
    int unsigned k, n, due_stale;
    bit got;
    mem_init[32'h300] = 32'h0403_02F1;
    mem_init[32'h304] = 32'hA5A5_A5A5;
    step(40);
    mem_lat = 20;
    seek_to(32'h300);
    wait_ack(80, k, got);
    tests_run++; if (bus.data !== 8'hF1) begin tests_failed++; $display("FAIL areset_pre_data: got %0h expected f1", bus.data); end
    n = 0;
    while (pend_q.size() == 0 && n < 10) begin step(); n++; end
    tests_run++; if (pend_q.size() == 0) begin tests_failed++; $display("FAIL areset_outstanding: no read outstanding within 10 cycles"); end
    due_stale = (pend_q.size() > 0) ? pend_q[0].due : cyc + 10;
    step(3);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    tests_run++; if (bus.data !== 8'h00) begin tests_failed++; $display("FAIL areset_data: got %0h expected 0", bus.data); end
    tests_run++; if (bus.data_ack !== 1'b0) begin tests_failed++; $display("FAIL areset_ack: got %0b expected 0", bus.data_ack); end
    tests_run++; if (bus.mem_rd !== 1'b0) begin tests_failed++; $display("FAIL areset_mem_rd: got %0b expected 0", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL areset_mem_addr: got %0h expected 0", bus.mem_addr); end
    tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL areset_underflow: got %0b expected 0", bus.underflow); end
    // Release just after the stale response is driven, so the first free edge samples it.
    n = 0;
    while (cyc < due_stale && n < 40) begin step(); n++; end
    RST = 1'b0;
    step();
    tests_run++; if (bus.mem_rd !== 1'b1) begin tests_failed++; $display("FAIL areset_refetch_rd: got %0b expected 1", bus.mem_rd); end
    tests_run++; if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL areset_refetch_addr: got %0h expected 0", bus.mem_addr); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (bus.data !== 8'h00) begin tests_failed++; $display("FAIL areset_stale_data%0d: got %0h expected 0", i, bus.data); end
      tests_run++; if (bus.data_ack !== 1'b0) begin tests_failed++; $display("FAIL areset_stale_ack%0d: got %0b expected 0", i, bus.data_ack); end
      step();
    end
  endtask

  initial begin
    bus.data_addr = '0;
    bus.data_seek = 1'b0;
    bus.data_req  = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_prefetch_limit();
    test_seek_outstanding();
    test_underflow();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
